register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 Parameter DEPTH, default 32, SHALL set the number of registers; legal values are 2..256.
REQ-003 Parameter ZERO_REG, default 1, SHALL make entry 0 hard-wired to zero when 1; when 0, entry 0 is an ordinary register.
REQ-004 Derived AW = clog2(DEPTH) SHALL be the address width, and NB = WIDTH/8 SHALL be the byte-strobe width.
REQ-005 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 we  input  1  SHALL be the write enable.
REQ-008 waddr  input  AW  SHALL be the write address.
REQ-009 wdata  input  WIDTH  SHALL be the write data.
REQ-010 wstrb  input  NB  SHALL be the byte write strobes; bit i qualifies wdata[8i+7:8i].
REQ-011 raddr_a, raddr_b  input  AW each  SHALL be the read addresses.
REQ-012 rdata_a, rdata_b  output  WIDTH each  SHALL be the read data.
REQ-013 bset  input  1  SHALL request that a register be marked busy (pending writer).
REQ-014 bset_addr  input  AW  SHALL select the register to mark busy.
REQ-015 busy_a, busy_b  output  1 each  SHALL be the busy flags of raddr_a and raddr_b.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH registers plus DEPTH busy bits.
REQ-017 At each clk edge with we=1, waddr<DEPTH, and the target not protected by REQ-019, each byte whose wstrb bit is 1 SHALL be updated from wdata; bytes whose strobe is 0 SHALL hold.
REQ-018 A write with we=1 and wstrb all zeros SHALL leave the data unchanged but SHALL still clear the busy bit per REQ-023.
REQ-019 With ZERO_REG=1, writes to entry 0 SHALL be ignored, entry 0 SHALL always read 0, and its busy bit SHALL always read 0.
REQ-020 Reads SHALL be combinational from raddr; an address >= DEPTH SHALL read 0 with busy 0, and writes to such an address SHALL be ignored.
REQ-021 Write-through bypass: when we=1 and raddr_x==waddr (target writable), rdata_x SHALL equal the post-write value in the same cycle (strobed bytes from wdata, unstrobed bytes from storage).
REQ-022 bset=1 SHALL set busy[bset_addr] at the clk edge.
REQ-023 we=1 SHALL clear busy[waddr] at the clk edge.
REQ-024 With bset=1 and we=1 at the same address in the same cycle, set SHALL win and the bit SHALL end at 1, because a new writer is issued.
REQ-025 busy_x SHALL reflect the stored bit combinationally with no bypass; a clear or set becomes visible the cycle after the edge.
REQ-026 Both read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-027 Write latency SHALL be 1 cycle to storage and 0 cycles through the bypass.

Reset
REQ-028 While rst=1, asynchronously and regardless of clk, all data entries and all busy bits SHALL be 0; rdata_a, rdata_b, busy_a and busy_b SHALL be 0 for every address.
REQ-029 Writes and bset asserted while rst=1 SHALL have no effect; operation SHALL resume at the first clk edge after rst deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all contents and pending busy state immediately, without waiting for clk.

Verification
REQ-031 With rst pulsed, reading every address on both ports SHALL give rdata_x=0 and busy_x=0.
REQ-032 Write waddr=5, wdata=0x1122334455667788, wstrb=0xFF, then write waddr=5, wdata=0xAAAA..AA, wstrb=0x0F -> entry 5 = 0x11223344AAAAAAAA, and the same cycle's rdata_a with raddr_a=5 shows that value through the bypass.
REQ-033 With ZERO_REG=1, write waddr=0, wdata=all ones, wstrb=0xFF, plus bset at address 0 -> rdata_a=0 and busy_a=0 for raddr_a=0.
REQ-034 bset at address 7 (cycle n) -> busy_a=1 from n+1; we at address 7 (cycle n+2) -> busy_a=0 from n+3; bset plus we at address 7 in the same cycle -> busy_a=1 after the edge.
REQ-035 Load entries 3 and 9, assert rst between clock edges -> rdata and busy read 0 at once, before the next edge; a write issued with rst high is ignored.
REQ-036 With WIDTH=32 and DEPTH=8, write address 7 and read address 7 -> correct data; raddr=7 with wstrb=0x5 merges bytes 0 and 2 only.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : Two-read/one-write register file with byte strobes, a write-through
//            bypass and per-entry busy (pending writer) bits.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [WIDTH/8-1:0]       wstrb,
   input  logic [$clog2(DEPTH)-1:0] raddr_a,
   input  logic [$clog2(DEPTH)-1:0] raddr_b,
   output logic [WIDTH-1:0]         rdata_a,
   output logic [WIDTH-1:0]         rdata_b,
   input  logic                     bset,
   input  logic [$clog2(DEPTH)-1:0] bset_addr,
   output logic                     busy_a,
   output logic                     busy_b
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          NB      = WIDTH / 8;
   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

   // An entry is usable when it exists and is not the hard-wired zero entry
   function automatic logic addr_ok(input logic [AW-1:0] addr);
      return ({1'b0, addr} < c_depth) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic             w_wr_ok;
   logic             w_bset_ok;
   logic [WIDTH-1:0] w_old;
   logic [WIDTH-1:0] w_merged;

   assign w_wr_ok   = we && addr_ok(waddr);
   assign w_bset_ok = bset && addr_ok(bset_addr);
   assign w_old     = w_wr_ok ? r_mem[waddr] : '0;

   generate
      for (genvar i = 0; i < NB; i++) begin : g_byte
         assign w_merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : w_old[8*i +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_mem[waddr]  <= w_merged;
            r_busy[waddr] <= 1'b0;
         end
         // A newly issued writer outranks the one retiring at the same entry
         if (w_bset_ok) begin
            r_busy[bset_addr] <= 1'b1;
         end
      end
   end

   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [AW-1:0]    w_addr;
         logic             w_valid;
         logic             w_hit;
         logic [WIDTH-1:0] w_rdata;
         logic             w_busy;

         assign w_addr  = (p == 0) ? raddr_a : raddr_b;
         assign w_valid = !rst && addr_ok(w_addr);
         assign w_hit   = w_wr_ok && (w_addr == waddr);
         assign w_rdata = !w_valid ? '0 : (w_hit ? w_merged : r_mem[w_addr]);
         assign w_busy  = w_valid && r_busy[w_addr];
      end
   endgenerate

   assign rdata_a = g_port[0].w_rdata;
   assign rdata_b = g_port[1].w_rdata;
   assign busy_a  = g_port[0].w_busy;
   assign busy_b  = g_port[1].w_busy;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   // Main instance: 64 x 32, zero register
   logic        we0, bset0, busy_a0, busy_b0;
   logic [4:0]  waddr0, ra0, rb0, baddr0;
   logic [63:0] wdata0, rd_a0, rd_b0;
   logic [7:0]  wstrb0;

   // 32 x 8, entry 0 ordinary
   logic        we1, bset1, busy_a1, busy_b1;
   logic [2:0]  waddr1, ra1, rb1, baddr1;
   logic [31:0] wdata1, rd_a1, rd_b1;
   logic [3:0]  wstrb1;

   // 8 x 5, addresses 5..7 do not exist
   logic        we2, bset2, busy_a2, busy_b2;
   logic [2:0]  waddr2, ra2, rb2, baddr2;
   logic [7:0]  wdata2, rd_a2, rd_b2;
   logic [0:0]  wstrb2;

   register_file #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1)) dut0 (
      .clk(clk), .rst(rst), .we(we0), .waddr(waddr0), .wdata(wdata0), .wstrb(wstrb0),
      .raddr_a(ra0), .raddr_b(rb0), .rdata_a(rd_a0), .rdata_b(rd_b0),
      .bset(bset0), .bset_addr(baddr0), .busy_a(busy_a0), .busy_b(busy_b0));

   register_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0)) dut1 (
      .clk(clk), .rst(rst), .we(we1), .waddr(waddr1), .wdata(wdata1), .wstrb(wstrb1),
      .raddr_a(ra1), .raddr_b(rb1), .rdata_a(rd_a1), .rdata_b(rd_b1),
      .bset(bset1), .bset_addr(baddr1), .busy_a(busy_a1), .busy_b(busy_b1));

   register_file #(.WIDTH(8), .DEPTH(5), .ZERO_REG(0)) dut2 (
      .clk(clk), .rst(rst), .we(we2), .waddr(waddr2), .wdata(wdata2), .wstrb(wstrb2),
      .raddr_a(ra2), .raddr_b(rb2), .rdata_a(rd_a2), .rdata_b(rd_b2),
      .bset(bset2), .bset_addr(baddr2), .busy_a(busy_a2), .busy_b(busy_b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the main instance
   logic [63:0] m_mem  [32];
   bit          m_busy [32];

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] s);
      logic [63:0] res;
      res = old;
      for (int b = 0; b < 8; b++) begin
         if (s[b]) res[8*b +: 8] = d[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [63:0] exp_rd(input logic [4:0] addr);
      if (rst || addr == 0) return 64'd0;
      if (we0 && waddr0 == addr) return merge(m_mem[addr], wdata0, wstrb0);
      return m_mem[addr];
   endfunction

   function automatic logic exp_busy(input logic [4:0] addr);
      if (rst || addr == 0) return 1'b0;
      return m_busy[addr];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 64'd0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_ports0(input string tag);
      check({tag, ".rda"},  rd_a0,   exp_rd(ra0));
      check({tag, ".rdb"},  rd_b0,   exp_rd(rb0));
      check({tag, ".bsya"}, 64'(busy_a0), 64'(exp_busy(ra0)));
      check({tag, ".bsyb"}, 64'(busy_b0), 64'(exp_busy(rb0)));
   endtask

   task automatic set0(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [7:0] ws, input logic [4:0] ra, input logic [4:0] rb,
                       input logic bs, input logic [4:0] ba);
      we0 = we; waddr0 = wa; wdata0 = wd; wstrb0 = ws;
      ra0 = ra; rb0 = rb; bset0 = bs; baddr0 = ba;
      #1;
   endtask

   // Advance one clock; the model applies the write first, then the busy set
   task automatic tick0();
      @(posedge clk);
      if (!rst) begin
         if (we0 && waddr0 != 0) begin
            m_mem[waddr0]  = merge(m_mem[waddr0], wdata0, wstrb0);
            m_busy[waddr0] = 1'b0;
         end
         if (bset0 && baddr0 != 0) m_busy[baddr0] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_clear();
      rst = 1'b1;
      we0 = 0; waddr0 = 0; wdata0 = 0; wstrb0 = 0; ra0 = 0; rb0 = 0; bset0 = 0; baddr0 = 0;
      we1 = 0; waddr1 = 0; wdata1 = 0; wstrb1 = 0; ra1 = 0; rb1 = 0; bset1 = 0; baddr1 = 0;
      we2 = 0; waddr2 = 0; wdata2 = 0; wstrb2 = 0; ra2 = 0; rb2 = 0; bset2 = 0; baddr2 = 0;
      repeat (2) @(negedge clk);

      // Reset: every address reads zero, even with a bypassing write pending
      we1 = 1; waddr1 = 2; wdata1 = '1; wstrb1 = '1; ra1 = 2;
      for (int a = 0; a < 32; a++) begin
         set0(1'b1, 5'(a), '1, 8'hFF, 5'(a), 5'(31 - a), 1'b1, 5'(a));
         check("rst.rda",  rd_a0, 64'd0);
         check("rst.rdb",  rd_b0, 64'd0);
         check("rst.bsya", 64'(busy_a0), 64'd0);
         check("rst.bsyb", 64'(busy_b0), 64'd0);
      end
      check("rst.dut1", 64'(rd_a1), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      we1 = 0;
      set0(0, 0, 0, 0, 5, 9, 0, 0);
      check_ports0("post_rst");
      tick0();

      // Full write then low-half strobed write to entry 5
      set0(1, 5, 64'h1122334455667788, 8'hFF, 5, 5, 0, 0);
      check("byp5a", rd_a0, 64'h1122334455667788);
      check_ports0("w5a");
      tick0();
      set0(1, 5, {8{8'hAA}}, 8'h0F, 5, 5, 0, 0);
      check("byp5b", rd_a0, 64'h11223344AAAAAAAA);
      check_ports0("w5b");
      tick0();
      set0(0, 0, 0, 0, 5, 5, 0, 0);
      check("store5", rd_a0, 64'h11223344AAAAAAAA);
      tick0();

      // Strobe-less write keeps data but still retires the busy bit
      set0(0, 0, 0, 0, 5, 0, 1, 5);
      tick0();
      set0(1, 5, '1, 8'h00, 5, 5, 0, 0);
      check("nostrb.busy", 64'(busy_a0), 64'd1);
      check("nostrb.data", rd_a0, 64'h11223344AAAAAAAA);
      tick0();
      set0(0, 0, 0, 0, 5, 5, 0, 0);
      check("nostrb.clr", 64'(busy_a0), 64'd0);
      tick0();

      // Entry 0 is hard-wired zero and never busy
      set0(1, 0, '1, 8'hFF, 0, 0, 1, 0);
      check("z0.byp", rd_a0, 64'd0);
      tick0();
      set0(0, 0, 0, 0, 0, 0, 0, 0);
      check("z0.rd",   rd_a0, 64'd0);
      check("z0.busy", 64'(busy_a0), 64'd0);
      tick0();

      // Busy set / clear timing and set-wins collision at entry 7
      set0(0, 0, 0, 0, 7, 7, 1, 7);
      check("b7.n", 64'(busy_a0), 64'd0);
      tick0();
      set0(0, 0, 0, 0, 7, 7, 0, 0);
      check("b7.n1", 64'(busy_a0), 64'd1);
      tick0();
      set0(1, 7, 64'h0123456789ABCDEF, 8'hFF, 7, 7, 0, 0);
      check("b7.n2", 64'(busy_a0), 64'd1);
      tick0();
      set0(0, 0, 0, 0, 7, 7, 0, 0);
      check("b7.n3", 64'(busy_a0), 64'd0);
      tick0();
      set0(1, 7, 64'h5, 8'hFF, 7, 7, 1, 7);
      tick0();
      set0(0, 0, 0, 0, 7, 7, 0, 0);
      check("b7.win", 64'(busy_a0), 64'd1);
      check_ports0("b7");
      tick0();

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa;
         wa = 5'($urandom);
         set0(1'($urandom), wa, {$urandom, $urandom}, 8'($urandom),
              ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
              ($urandom_range(0, 2) == 0) ? wa : 5'($urandom),
              ($urandom_range(0, 3) == 0), 5'($urandom));
         check_ports0("rnd");
         tick0();
      end

      // Asynchronous reset between clock edges
      set0(1, 3, 64'hCAFE, 8'hFF, 3, 9, 1, 3);
      tick0();
      set0(1, 9, 64'hBEEF0000, 8'hFF, 3, 9, 1, 9);
      tick0();
      set0(0, 0, 0, 0, 3, 9, 0, 0);
      check_ports0("preload");
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      check("arst.rda",  rd_a0, 64'd0);
      check("arst.rdb",  rd_b0, 64'd0);
      check("arst.bsya", 64'(busy_a0), 64'd0);
      check("arst.bsyb", 64'(busy_b0), 64'd0);
      set0(1, 3, 64'hDEAD, 8'hFF, 3, 9, 1, 3);
      tick0();
      rst = 1'b0;
      set0(0, 0, 0, 0, 3, 9, 0, 0);
      check("arst.ign",  rd_a0, 64'd0);
      check("arst.ignb", 64'(busy_a0), 64'd0);
      check_ports0("arst");
      tick0();

      // 32-bit x 8 instance: top entry, byte merge, ordinary entry 0
      we1 = 1; waddr1 = 7; wdata1 = 32'hDEADBEEF; wstrb1 = 4'hF; ra1 = 7; rb1 = 0;
      #1;
      check("d1.byp7", 64'(rd_a1), 64'hDEADBEEF);
      @(posedge clk); @(negedge clk);
      wdata1 = 32'h11223344; wstrb1 = 4'h5;
      #1;
      check("d1.merge.byp", 64'(rd_a1), 64'hDE22BE44);
      @(posedge clk); @(negedge clk);
      we1 = 1; waddr1 = 0; wdata1 = 32'h0000A5A5; wstrb1 = 4'hF; bset1 = 1; baddr1 = 0;
      rb1 = 7;
      #1;
      check("d1.merge.st", 64'(rd_b1), 64'hDE22BE44);
      @(posedge clk); @(negedge clk);
      we1 = 0; bset1 = 0; ra1 = 0;
      #1;
      check("d1.e0.data", 64'(rd_a1), 64'h0000A5A5);
      check("d1.e0.busy", 64'(busy_a1), 64'd1);

      // 8-bit x 5 instance: out-of-range addresses
      we2 = 1; waddr2 = 4; wdata2 = 8'hC3; wstrb2 = 1'b1; ra2 = 4; rb2 = 6;
      #1;
      check("d2.byp4", 64'(rd_a2), 64'hC3);
      check("d2.oor",  64'(rd_b2), 64'd0);
      @(posedge clk); @(negedge clk);
      waddr2 = 6; wdata2 = 8'h5A; bset2 = 1; baddr2 = 6; ra2 = 6; rb2 = 4;
      #1;
      check("d2.oor.byp", 64'(rd_a2), 64'd0);
      check("d2.st4",     64'(rd_b2), 64'hC3);
      @(posedge clk); @(negedge clk);
      we2 = 0; bset2 = 0;
      #1;
      check("d2.oor.rd",   64'(rd_a2), 64'd0);
      check("d2.oor.busy", 64'(busy_a2), 64'd0);
      check("d2.st4b",     64'(rd_b2), 64'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
